matmul_sequencer: RTL and testbench



---
 rtl/matmul_pkg.sv | 26 ++
 rtl/matmul_sequencer_counter.sv | 30 +++
 rtl/matmul_sequencer.sv | 147 ++++++++++++++
 tb/tb_matmul_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply control path: sequencer
// state encoding, operand-dimension derivation and the K clamp.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic int calc_max_dim(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

    function automatic int calc_dim_w(input int max_dim);
        return $clog2(max_dim) + 1;
    endfunction

    // Out-of-range K (zero or wider than the bus) falls back to the full bus.
    function automatic int clamp_dim(input int k, input int max_dim);
        return ((k <= 0) || (k > max_dim)) ? max_dim : k;
    endfunction

endpackage

// File: rtl/matmul_sequencer_counter.sv
// Up-counter with clear priority and a terminal-count compare against a
// caller-supplied last value; shared by the FEED and DRAIN phases.
module seq_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] last_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else if (clr_i) begin
            count_reg <= '0;
        end else if (en_i) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count_o = count_reg;
    assign tc_o    = (count_reg == last_i);

endmodule

// File: rtl/matmul_sequencer.sv
// Control FSM for the matrix-multiply datapath: arbitrates host bank writes,
// clears accumulators, drives the skewed operand feed, drains the PEs, signals done.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int  DATA_WIDTH   = 32,
    parameter int  BUS_WIDTH    = 64,
    parameter int  DRAIN_CYCLES = 4,
    localparam int MAX_DIM      = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
    localparam int DIM_W        = calc_dim_w(MAX_DIM),
    localparam int CNT_W        = $clog2(2 * MAX_DIM + DRAIN_CYCLES) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [DIM_W-1:0] k_dim_i,
    input  logic             host_wr_req_i,
    output logic             host_wr_gnt_o,
    output logic             start_send_o,
    output logic [CNT_W-1:0] feed_idx_o,
    output logic             acc_clear_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] SKEW       = CNT_W'(MAX_DIM - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_e           state_reg;
    logic [DIM_W-1:0] k_lat_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             acc_clear_reg;
    logic             start_send_reg;

    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_last;
    logic [CNT_W-1:0] cnt_value;
    logic [CNT_W-1:0] feed_last;

    // The grant ignores the request itself: a waiting request just stays pending.
    logic unused_host_req;
    assign unused_host_req = host_wr_req_i;

    // Feed window spans K beats plus the MAX_DIM-1 beat skew of the array.
    assign feed_last = CNT_W'(k_lat_reg) + SKEW - ONE;

    always_comb begin
        cnt_clr  = 1'b1;
        cnt_en   = 1'b0;
        cnt_last = '0;
        case (state_reg)
            ST_FEED: begin
                cnt_last = feed_last;
                cnt_clr  = abort_i | cnt_tc;
                cnt_en   = 1'b1;
            end
            ST_DRAIN: begin
                cnt_last = DRAIN_LAST;
                cnt_clr  = abort_i | cnt_tc;
                cnt_en   = 1'b1;
            end
            default: ;
        endcase
    end

    seq_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .last_i (cnt_last),
        .count_o(cnt_value),
        .tc_o   (cnt_tc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= ST_IDLE;
            k_lat_reg      <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            acc_clear_reg  <= 1'b0;
            start_send_reg <= 1'b0;
        end else if (abort_i && (state_reg != ST_IDLE)) begin
            state_reg      <= ST_IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            acc_clear_reg  <= 1'b0;
            start_send_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_i) begin
                        state_reg     <= ST_CLEAR;
                        k_lat_reg     <= DIM_W'(clamp_dim(int'(k_dim_i), MAX_DIM));
                        busy_reg      <= 1'b1;
                        acc_clear_reg <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state_reg      <= ST_FEED;
                    acc_clear_reg  <= 1'b0;
                    start_send_reg <= 1'b1;
                end
                ST_FEED: begin
                    if (cnt_tc) begin
                        state_reg      <= ST_DRAIN;
                        start_send_reg <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_tc) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    busy_reg       <= 1'b0;
                    done_reg       <= 1'b0;
                    acc_clear_reg  <= 1'b0;
                    start_send_reg <= 1'b0;
                end
            endcase
        end
    end

    assign host_wr_gnt_o = (state_reg == ST_IDLE) & ~start_i;
    assign start_send_o  = start_send_reg;
    assign feed_idx_o    = (state_reg == ST_FEED) ? cnt_value : '0;
    assign acc_clear_o   = acc_clear_reg;
    assign busy_o        = busy_reg;
    assign done_o        = done_reg;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Randomized plus directed bench for matmul_sequencer, checked against an
// offset-based timeline model of each run (MAX_DIM=2, DRAIN_CYCLES=4).
module tb_matmul_sequencer;

    localparam int MAX_DIM = 2;
    localparam int DRAIN   = 4;
    localparam int DIM_W   = 2;
    localparam int CNT_W   = 4;

    logic             clk_i;
    logic             rst_ni;
    logic             start_i;
    logic             abort_i;
    logic [DIM_W-1:0] k_dim_i;
    logic             host_wr_req_i;
    logic             host_wr_gnt_o;
    logic             start_send_o;
    logic [CNT_W-1:0] feed_idx_o;
    logic             acc_clear_o;
    logic             busy_o;
    logic             done_o;

    int errors = 0;
    int checks = 0;

    // Model: one run is a timeline indexed by cycles since the start edge.
    bit m_run = 0;
    int m_ofs = 0;
    int m_fl  = 0;
    int m_dones = 0;

    matmul_sequencer #(
        .DATA_WIDTH  (32),
        .BUS_WIDTH   (64),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .k_dim_i      (k_dim_i),
        .host_wr_req_i(host_wr_req_i),
        .host_wr_gnt_o(host_wr_gnt_o),
        .start_send_o (start_send_o),
        .feed_idx_o   (feed_idx_o),
        .acc_clear_o  (acc_clear_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int done_ofs;
        bit send;
        done_ofs = m_fl + DRAIN + 2;
        send = m_run && (m_ofs >= 2) && (m_ofs <= m_fl + 1);
        check_eq("acc_clear", int'(acc_clear_o), int'(m_run && m_ofs == 1));
        check_eq("start_send", int'(start_send_o), int'(send));
        check_eq("feed_idx", int'(feed_idx_o), send ? m_ofs - 2 : 0);
        check_eq("busy", int'(busy_o), int'(m_run));
        check_eq("done", int'(done_o), int'(m_run && m_ofs == done_ofs));
    endtask

    // One clock cycle: drive inputs mid-cycle, check grant, advance model at the edge.
    task automatic step(input bit st, input int k, input bit ab, input bit rq);
        int kc;
        @(negedge clk_i);
        start_i       = st;
        k_dim_i       = DIM_W'(k);
        abort_i       = ab;
        host_wr_req_i = rq;
        #1;
        check_eq("gnt", int'(host_wr_gnt_o), int'(!m_run && !st));
        @(posedge clk_i);
        if (!m_run) begin
            if (st) begin
                kc    = (k == 0 || k > MAX_DIM) ? MAX_DIM : k;
                m_fl  = kc + MAX_DIM - 1;
                m_run = 1;
                m_ofs = 1;
            end
        end else if (ab) begin
            m_run = 0;
        end else begin
            m_ofs++;
            if (m_ofs > m_fl + DRAIN + 2) m_run = 0;
        end
        #1;
        check_outputs();
        if (done_o) $display("done pulse at %0t (fl=%0d)", $time, m_fl);
        if (m_run && m_ofs == m_fl + DRAIN + 2) m_dones++;
    endtask

    task automatic idle_cycles(input int n, input bit rq);
        for (int i = 0; i < n; i++) step(0, 0, 0, rq);
    endtask

    initial begin
        int dones_before;
        rst_ni        = 1'b0;
        start_i       = 1'b0;
        abort_i       = 1'b0;
        k_dim_i       = '0;
        host_wr_req_i = 1'b0;
        #12;
        check_eq("rst_gnt", int'(host_wr_gnt_o), 1);
        check_eq("rst_busy", int'(busy_o), 0);
        check_eq("rst_send", int'(start_send_o), 0);
        check_eq("rst_done", int'(done_o), 0);
        check_eq("rst_clear", int'(acc_clear_o), 0);
        check_eq("rst_idx", int'(feed_idx_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle_cycles(2, 0);

        // Nominal run and clamp cases: k=2, 0, 3, 1.
        step(1, 2, 0, 0);
        idle_cycles(11, 0);
        step(1, 0, 0, 0);
        idle_cycles(11, 0);
        step(1, 3, 0, 0);
        idle_cycles(11, 0);
        step(1, 1, 0, 0);
        idle_cycles(10, 0);

        // Held host request across a run, including the start cycle.
        idle_cycles(2, 1);
        step(1, 2, 0, 1);
        idle_cycles(12, 1);

        // Abort in the third FEED cycle, then a clean run.
        step(1, 2, 0, 0);
        idle_cycles(3, 0);
        step(0, 0, 1, 0);
        idle_cycles(10, 0);
        step(1, 2, 0, 0);
        idle_cycles(11, 0);

        // Start and k change during DRAIN are ignored; exactly one done.
        dones_before = m_dones;
        step(1, 2, 0, 0);
        idle_cycles(5, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        idle_cycles(6, 0);
        check_eq("single_done", m_dones - dones_before, 1);

        // Abort on the final DRAIN cycle wins over done.
        step(1, 2, 0, 0);
        idle_cycles(7, 0);
        step(0, 0, 1, 0);
        idle_cycles(4, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 5) == 0, int'($urandom_range(0, 3)),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
        end
        idle_cycles(12, 0);

        // Asynchronous reset in the middle of FEED.
        step(1, 2, 0, 0);
        idle_cycles(2, 0);
        #3;
        rst_ni = 1'b0;
        #1;
        check_eq("arst_send", int'(start_send_o), 0);
        check_eq("arst_busy", int'(busy_o), 0);
        check_eq("arst_gnt", int'(host_wr_gnt_o), 1);
        m_run = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle_cycles(2, 0);
        step(1, 2, 0, 0);
        idle_cycles(11, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
